// File: rtl/mem_lsu_pkg.sv
// Shared encodings, widths and decode helpers for the load/store unit.
// Imported by mem_align, mem_lsu and the bench.
package mem_lsu_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic                  RstEnable    = 1'b1;
  localparam logic                  WriteDisable = 1'b0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
  localparam logic [RegBus-1:0]     ZeroWord     = '0;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LB  = 4'd1,
    OP_LH  = 4'd2,
    OP_LW  = 4'd3,
    OP_LBU = 4'd4,
    OP_LHU = 4'd5,
    OP_SB  = 4'd6,
    OP_SH  = 4'd7,
    OP_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

  function automatic logic is_load(logic [3:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(logic [3:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic is_misaligned(logic [3:0] op, logic [1:0] lo);
    return ((op inside {OP_LH, OP_LHU, OP_SH}) && lo[0]) ||
           ((op inside {OP_LW, OP_SW}) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store byte enables / replicated write data, and
// load lane extraction with sign or zero extension.
module mem_align
  import mem_lsu_pkg::*;
(
  input  logic [3:0]        op,
  input  logic [1:0]        addr_lo,
  input  logic [RegBus-1:0] sdata,
  input  logic [RegBus-1:0] rdata,
  output logic [3:0]        be,
  output logic [RegBus-1:0] wdata,
  output logic [RegBus-1:0] ldata
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Loads also get lane enables so the bus sees which bytes are read.
  always_comb begin
    be    = 4'b0000;
    wdata = ZeroWord;
    ldata = ZeroWord;
    case (op)
      OP_LB:  begin ldata = {{24{lane_b[7]}}, lane_b};  be = 4'b0001 << addr_lo; end
      OP_LBU: begin ldata = {24'd0, lane_b};             be = 4'b0001 << addr_lo; end
      OP_LH:  begin ldata = {{16{lane_h[15]}}, lane_h}; be = addr_lo[1] ? 4'b1100 : 4'b0011; end
      OP_LHU: begin ldata = {16'd0, lane_h};             be = addr_lo[1] ? 4'b1100 : 4'b0011; end
      OP_LW:  begin ldata = rdata;                       be = 4'b1111; end
      OP_SB:  begin wdata = {4{sdata[7:0]}};             be = 4'b0001 << addr_lo; end
      OP_SH:  begin wdata = {2{sdata[15:0]}};            be = addr_lo[1] ? 4'b1100 : 4'b0011; end
      OP_SW:  begin wdata = sdata;                       be = 4'b1111; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: stalls the pipeline while a data-bus
// transaction is in flight and hands the aligned result to mem_wb.
//
// state  | meaning
// IDLE   | pass-through / evaluate op, issue request same cycle
// REQ    | request held until dbus_gnt
// WAIT   | granted, waiting for dbus_rvalid
// DONE   | one unstalled cycle presenting result or bus error
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int BUS_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegAddrBus-1:0] ex_reg_waddr,
  input  logic                  ex_reg_we,
  input  logic [RegBus-1:0]     ex_reg_wdata,
  input  logic [3:0]            ex_mem_op,
  input  logic [RegBus-1:0]     ex_mem_addr,
  input  logic [RegBus-1:0]     ex_mem_sdata,
  output logic [RegAddrBus-1:0] mem_reg_waddr,
  output logic                  mem_reg_we,
  output logic [RegBus-1:0]     mem_reg_wdata,
  output logic                  stallreq,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [RegBus-1:0]     dbus_addr,
  output logic [3:0]            dbus_be,
  output logic [RegBus-1:0]     dbus_wdata,
  input  logic                  dbus_gnt,
  input  logic                  dbus_rvalid,
  input  logic [RegBus-1:0]     dbus_rdata,
  output logic                  mem_misalign,
  output logic                  mem_bus_err
);

  localparam int TW = $clog2(BUS_TIMEOUT + 1);

  lsu_state_e            state;
  logic [TW-1:0]         tmr;
  logic [3:0]            op_q;
  logic [1:0]            lo_q;
  logic [RegAddrBus-1:0] waddr_q;
  logic                  we_q;
  logic                  bwe_q;
  logic [RegBus-1:0]     baddr_q;
  logic [3:0]            be_q;
  logic [RegBus-1:0]     bwdata_q;
  logic [RegBus-1:0]     rdata_q;
  logic                  err_q;

  logic                  mem_op;
  logic                  misalign;
  logic                  issue;
  logic [3:0]            al_op;
  logic [1:0]            al_lo;
  logic [3:0]            al_be;
  logic [RegBus-1:0]     al_wdata;
  logic [RegBus-1:0]     al_ldata;

  assign mem_op   = is_load(ex_mem_op) || is_store(ex_mem_op);
  assign misalign = is_misaligned(ex_mem_op, ex_mem_addr[1:0]);
  assign issue    = (state == S_IDLE) && mem_op && !misalign;

  // Store steering is needed in IDLE, load extraction in WAIT.
  assign al_op = (state == S_IDLE) ? ex_mem_op : op_q;
  assign al_lo = (state == S_IDLE) ? ex_mem_addr[1:0] : lo_q;

  mem_align u_align (
    .op      (al_op),
    .addr_lo (al_lo),
    .sdata   (ex_mem_sdata),
    .rdata   (dbus_rdata),
    .be      (al_be),
    .wdata   (al_wdata),
    .ldata   (al_ldata)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state    <= S_IDLE;
      tmr      <= '0;
      op_q     <= OP_NOP;
      lo_q     <= 2'b00;
      waddr_q  <= NOPRegAddr;
      we_q     <= WriteDisable;
      bwe_q    <= 1'b0;
      baddr_q  <= ZeroWord;
      be_q     <= 4'b0000;
      bwdata_q <= ZeroWord;
      rdata_q  <= ZeroWord;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            op_q     <= ex_mem_op;
            lo_q     <= ex_mem_addr[1:0];
            waddr_q  <= ex_reg_waddr;
            we_q     <= ex_reg_we;
            bwe_q    <= is_store(ex_mem_op);
            baddr_q  <= {ex_mem_addr[31:2], 2'b00};
            be_q     <= al_be;
            bwdata_q <= al_wdata;
            rdata_q  <= ZeroWord;
            err_q    <= 1'b0;
            tmr      <= TW'(BUS_TIMEOUT - 1);
            state    <= dbus_gnt ? S_WAIT : S_REQ;
          end
        end
        S_REQ: begin
          // rvalid here is deliberately ignored, even alongside gnt.
          if (tmr == '0) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else begin
            tmr <= tmr - TW'(1);
            if (dbus_gnt) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (dbus_rvalid) begin
            rdata_q <= al_ldata;
            state   <= S_DONE;
          end else if (tmr == '0) begin
            err_q <= 1'b1;
            state <= S_DONE;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_DONE: begin
          err_q <= 1'b0;
          tmr   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_reg_waddr = NOPRegAddr;
    mem_reg_we    = WriteDisable;
    mem_reg_wdata = ZeroWord;
    stallreq      = 1'b0;
    dbus_req      = 1'b0;
    dbus_we       = 1'b0;
    dbus_addr     = ZeroWord;
    dbus_be       = 4'b0000;
    dbus_wdata    = ZeroWord;
    mem_misalign  = 1'b0;
    mem_bus_err   = 1'b0;
    if (rst != RstEnable) begin
      case (state)
        S_IDLE: begin
          mem_reg_waddr = ex_reg_waddr;
          mem_reg_wdata = ex_reg_wdata;
          if (!mem_op) begin
            mem_reg_we = ex_reg_we;
          end else if (misalign) begin
            mem_misalign = 1'b1;
          end else begin
            stallreq   = 1'b1;
            dbus_req   = 1'b1;
            dbus_we    = is_store(ex_mem_op);
            dbus_addr  = {ex_mem_addr[31:2], 2'b00};
            dbus_be    = al_be;
            dbus_wdata = al_wdata;
          end
        end
        S_REQ: begin
          stallreq   = 1'b1;
          dbus_req   = 1'b1;
          dbus_we    = bwe_q;
          dbus_addr  = baddr_q;
          dbus_be    = be_q;
          dbus_wdata = bwdata_q;
        end
        S_WAIT: stallreq = 1'b1;
        S_DONE: begin
          mem_reg_waddr = waddr_q;
          mem_reg_wdata = rdata_q;
          mem_reg_we    = we_q && is_load(op_q) && !err_q;
          mem_bus_err   = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: single-cycle IDLE behaviour from a vector
// table, then hand-written multi-cycle bus transactions.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_reg_waddr;
  logic        ex_reg_we;
  logic [31:0] ex_reg_wdata;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_mem_sdata;
  logic [4:0]  mem_reg_waddr;
  logic        mem_reg_we;
  logic [31:0] mem_reg_wdata;
  logic        stallreq;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_gnt;
  logic        dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        mem_misalign;
  logic        mem_bus_err;

  always #5 clk = ~clk;

  mem_lsu #(.BUS_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .ex_reg_waddr(ex_reg_waddr), .ex_reg_we(ex_reg_we), .ex_reg_wdata(ex_reg_wdata),
    .ex_mem_op(ex_mem_op), .ex_mem_addr(ex_mem_addr), .ex_mem_sdata(ex_mem_sdata),
    .mem_reg_waddr(mem_reg_waddr), .mem_reg_we(mem_reg_we), .mem_reg_wdata(mem_reg_wdata),
    .stallreq(stallreq),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
    .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .mem_misalign(mem_misalign), .mem_bus_err(mem_bus_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_ex(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] waddr, input logic we, input logic [31:0] wdata);
    ex_mem_op    = op;
    ex_mem_addr  = addr;
    ex_mem_sdata = sdata;
    ex_reg_waddr = waddr;
    ex_reg_we    = we;
    ex_reg_wdata = wdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dbus_gnt = 1'b0;
    dbus_rvalid = 1'b0;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, " ctl"}, {17'd0, mem_reg_waddr, mem_reg_we, stallreq, dbus_req, dbus_we,
                           dbus_be, mem_misalign, mem_bus_err}, 32'd0);
    check({name, " rwdata"}, mem_reg_wdata, 32'd0);
    check({name, " baddr"}, dbus_addr, 32'd0);
    check({name, " bwdata"}, dbus_wdata, 32'd0);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] wdata;
    logic        e_req;
    logic        e_stall;
    logic        e_mis;
    logic        e_rwe;
    logic        e_bwe;
    logic [31:0] e_baddr;
    logic [3:0]  e_be;
    logic [31:0] e_bwdata;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    //          op      addr          sdata         wa    we    wdata        req   stl   mis   rwe   bwe   baddr         be       bwdata
    vecs[0]  = '{OP_NOP, 32'h0000_0000, 32'h0,        5'd5, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        4'b0000, 32'h0};
    vecs[1]  = '{OP_NOP, 32'h0000_0000, 32'h0,        5'd31,1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        4'b0000, 32'h0};
    vecs[2]  = '{OP_LB,  32'h0000_1003, 32'h0,        5'd1, 1'b1, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 4'b1000, 32'h0};
    vecs[3]  = '{OP_LHU, 32'h0000_2002, 32'h0,        5'd2, 1'b1, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_2000, 4'b1100, 32'h0};
    vecs[4]  = '{OP_LW,  32'h0000_3000, 32'h0,        5'd3, 1'b1, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3000, 4'b1111, 32'h0};
    vecs[5]  = '{OP_SB,  32'h0000_4001, 32'h1234_5678, 5'd0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_4000, 4'b0010, 32'h7878_7878};
    vecs[6]  = '{OP_SB,  32'h0000_4003, 32'h1234_56A5, 5'd0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_4000, 4'b1000, 32'hA5A5_A5A5};
    vecs[7]  = '{OP_SH,  32'h0000_4000, 32'h1234_5678, 5'd0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_4000, 4'b0011, 32'h5678_5678};
    vecs[8]  = '{OP_SW,  32'h0000_400C, 32'hCAFE_F00D, 5'd0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_400C, 4'b1111, 32'hCAFE_F00D};
    vecs[9]  = '{OP_LW,  32'h0000_3001, 32'h0,        5'd9, 1'b1, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        4'b0000, 32'h0};
    vecs[10] = '{OP_LH,  32'h0000_5001, 32'h0,        5'd9, 1'b1, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        4'b0000, 32'h0};
    vecs[11] = '{OP_SW,  32'h0000_5002, 32'h0,        5'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        4'b0000, 32'h0};
    vecs[12] = '{OP_LHU, 32'h0000_5003, 32'h0,        5'd9, 1'b1, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        4'b0000, 32'h0};
    vecs[13] = '{OP_SH,  32'h0000_6003, 32'h0,        5'd0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        4'b0000, 32'h0};
    vecs[14] = '{OP_LB,  32'h0000_7001, 32'h0,        5'd4, 1'b1, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_7000, 4'b0010, 32'h0};

    dbus_rdata = 32'h0;
    // Reset with a live-looking op on the inputs: every output stays 0.
    set_ex(OP_LW, 32'h0000_8000, 32'h1111_2222, 5'd12, 1'b1, 32'h3333_4444);
    rst = 1'b1; dbus_gnt = 1'b1; dbus_rvalid = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    next_cycle();
    @(negedge clk);
    check_all_zero("reset2");

    for (int i = 0; i < NV; i++) begin
      do_reset();
      set_ex(vecs[i].op, vecs[i].addr, vecs[i].sdata, vecs[i].waddr, vecs[i].we, vecs[i].wdata);
      @(negedge clk);
      check($sformatf("v%0d req", i), {31'd0, dbus_req}, {31'd0, vecs[i].e_req});
      check($sformatf("v%0d stall", i), {31'd0, stallreq}, {31'd0, vecs[i].e_stall});
      check($sformatf("v%0d misalign", i), {31'd0, mem_misalign}, {31'd0, vecs[i].e_mis});
      check($sformatf("v%0d rwe", i), {31'd0, mem_reg_we}, {31'd0, vecs[i].e_rwe});
      if (vecs[i].op == OP_NOP) begin
        check($sformatf("v%0d rwaddr", i), {27'd0, mem_reg_waddr}, {27'd0, vecs[i].waddr});
        check($sformatf("v%0d rwdata", i), mem_reg_wdata, vecs[i].wdata);
      end
      if (vecs[i].e_req) begin
        check($sformatf("v%0d baddr", i), dbus_addr, vecs[i].e_baddr);
        check($sformatf("v%0d be", i), {28'd0, dbus_be}, {28'd0, vecs[i].e_be});
        check($sformatf("v%0d bwe", i), {31'd0, dbus_we}, {31'd0, vecs[i].e_bwe});
        if (vecs[i].e_bwe)
          check($sformatf("v%0d bwdata", i), dbus_wdata, vecs[i].e_bwdata);
      end
    end

    // LB with immediate grant, rvalid two cycles later, next op queued behind DONE.
    do_reset();
    set_ex(OP_LB, 32'h0000_1003, 32'h0, 5'd7, 1'b1, 32'h0);
    dbus_gnt = 1'b1;
    @(negedge clk);
    check("lb c0 stall", {31'd0, stallreq}, 32'd1);
    check("lb c0 req", {31'd0, dbus_req}, 32'd1);
    check("lb c0 rwe", {31'd0, mem_reg_we}, 32'd0);
    next_cycle();
    dbus_gnt = 1'b0;
    @(negedge clk);
    check("lb c1 stall/req", {30'd0, stallreq, dbus_req}, 32'b10);
    next_cycle();
    dbus_rvalid = 1'b1; dbus_rdata = 32'h80FF_FFFF;
    @(negedge clk);
    check("lb c2 stall", {31'd0, stallreq}, 32'd1);
    next_cycle();
    dbus_rvalid = 1'b0; dbus_rdata = 32'h0;
    set_ex(OP_LW, 32'h0000_5000, 32'h0, 5'd9, 1'b1, 32'h0);
    @(negedge clk);
    check("lb done stall/req", {30'd0, stallreq, dbus_req}, 32'b00);
    check("lb done rwe", {31'd0, mem_reg_we}, 32'd1);
    check("lb done rwaddr", {27'd0, mem_reg_waddr}, 32'd7);
    check("lb done rwdata", mem_reg_wdata, 32'hFFFF_FF80);
    next_cycle();
    @(negedge clk);
    check("b2b lw req/stall", {30'd0, stallreq, dbus_req}, 32'b11);
    check("b2b lw baddr", dbus_addr, 32'h0000_5000);

    // SH with grant delayed 3 cycles; gnt+rvalid together in REQ counts as gnt only.
    do_reset();
    set_ex(OP_SH, 32'h0000_2002, 32'h0000_ABCD, 5'd3, 1'b1, 32'h0);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin dbus_gnt = 1'b1; dbus_rvalid = 1'b1; end
      @(negedge clk);
      check($sformatf("sh c%0d req/stall/we", c), {29'd0, dbus_req, stallreq, dbus_we}, 32'b111);
      check($sformatf("sh c%0d baddr", c), dbus_addr, 32'h0000_2000);
      check($sformatf("sh c%0d be", c), {28'd0, dbus_be}, 32'b1100);
      check($sformatf("sh c%0d bwdata", c), dbus_wdata, 32'hABCD_ABCD);
      check($sformatf("sh c%0d rwe", c), {31'd0, mem_reg_we}, 32'd0);
      next_cycle();
    end
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    @(negedge clk);
    check("sh wait stall/req", {30'd0, stallreq, dbus_req}, 32'b10);
    next_cycle();
    dbus_rvalid = 1'b1;
    @(negedge clk);
    check("sh wait2 stall", {31'd0, stallreq}, 32'd1);
    next_cycle();
    dbus_rvalid = 1'b0;
    @(negedge clk);
    check("sh done stall/rwe/err", {29'd0, stallreq, mem_reg_we, mem_bus_err}, 32'b000);

    // Misaligned LW lasts one cycle and leaves the FSM idle.
    do_reset();
    set_ex(OP_LW, 32'h0000_3001, 32'h0, 5'd8, 1'b1, 32'h0);
    @(negedge clk);
    check("mis flags", {28'd0, mem_misalign, dbus_req, stallreq, mem_reg_we}, 32'b1000);
    next_cycle();
    set_ex(OP_NOP, 32'h0, 32'h0, 5'd2, 1'b1, 32'h55);
    @(negedge clk);
    check("mis next flags", {28'd0, mem_misalign, dbus_req, stallreq, mem_reg_we}, 32'b0001);
    check("mis next rwdata", mem_reg_wdata, 32'h55);

    // LW granted but never answered: bus error after 16 waiting cycles.
    do_reset();
    set_ex(OP_LW, 32'h0000_6000, 32'h0, 5'd4, 1'b1, 32'h0);
    dbus_gnt = 1'b1;
    next_cycle();
    dbus_gnt = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("to c%0d stall/err", k), {30'd0, stallreq, mem_bus_err}, 32'b10);
      next_cycle();
    end
    @(negedge clk);
    check("to done err/stall/rwe/req", {28'd0, mem_bus_err, stallreq, mem_reg_we, dbus_req}, 32'b1000);
    next_cycle();
    set_ex(OP_NOP, 32'h0, 32'h0, 5'd6, 1'b1, 32'h77);
    @(negedge clk);
    check("to idle err/stall/rwe", {29'd0, mem_bus_err, stallreq, mem_reg_we}, 32'b001);

    // Reset during WAIT, then a stray rvalid from the abandoned access.
    do_reset();
    set_ex(OP_LW, 32'h0000_7000, 32'h0, 5'd10, 1'b1, 32'h0);
    dbus_gnt = 1'b1;
    next_cycle();
    dbus_gnt = 1'b0;
    @(negedge clk);
    check("rw wait stall", {31'd0, stallreq}, 32'd1);
    next_cycle();
    rst = 1'b1;
    set_ex(OP_NOP, 32'h0, 32'h0, 5'd6, 1'b1, 32'h0000_0ABC);
    @(negedge clk);
    check_all_zero("rw in reset");
    next_cycle();
    rst = 1'b0;
    dbus_rvalid = 1'b1; dbus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rw stray flags", {28'd0, stallreq, mem_bus_err, mem_misalign, mem_reg_we}, 32'b0001);
    check("rw stray rwdata", mem_reg_wdata, 32'h0000_0ABC);
    next_cycle();
    dbus_rvalid = 1'b0;
    @(negedge clk);
    check("rw after flags", {29'd0, stallreq, mem_bus_err, dbus_req}, 32'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
